// File: rtl/mips_irq_ctrl_if.sv
// Bus between the mips core and the interrupt controller: config window plus request/ack/rti path.
interface mips_irq_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic        irq_ack;
  logic [31:0] ack_pc;
  logic        rti;
  logic [31:0] rti_pc;
  logic [3:0]  depth;
  logic        nest_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack, ack_pc, rti,
    input  cfg_rdata, irq_req, irq_vector, rti_pc, depth, nest_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack, ack_pc, rti,
    output cfg_rdata, irq_req, irq_vector, rti_pc, depth, nest_err
  );
endinterface

// File: rtl/mips_irq_ctrl.sv
// Vectored interrupt controller: latches, masks and prioritises N_IRQ sources (index 0 highest),
// offers one request at a time to the core and keeps a nested stack of {id, EPC} popped on rti.
module mips_irq_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter int          NEST_DEPTH = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
  parameter int          VEC_STRIDE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  mips_irq_ctrl_if.slave   bus
);
  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] mode;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] pend_next;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic             gie;
  logic             nest_err;
  logic [0:0]       state;
  logic [IDW-1:0]   req_id;
  logic [31:0]      vector;
  logic [IDW-1:0]   stack_id [NEST_DEPTH];
  logic [31:0]      stack_pc [NEST_DEPTH];
  logic [3:0]       depth_q;
  logic [3:0]       depth_pop;
  logic             cand_valid;
  logic [IDW-1:0]   cand_id;
  logic [IDW-1:0]   top_id;
  logic [31:0]      top_pc;
  logic             eligible;
  logic             ack_take;
  logic             rti_pop;
  logic             rti_err;
  logic             push_ok;
  logic             push_drop;
  logic             mask_we;
  logic             mode_we;
  logic             ctrl_we;
  logic             unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata;

  assign mask_we = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign mode_we = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign ctrl_we = bus.cfg_we && (bus.cfg_addr == 2'd3);

  // Highest-priority candidate: lowest index that is both pending and unmasked.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend[i] && mask[i]) begin
        cand_valid = 1'b1;
        cand_id    = IDW'(i);
      end
    end
  end

  // Top-of-stack lookup; both fields read as zero when nothing is in service.
  always_comb begin
    top_id = '0;
    top_pc = '0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (depth_q == 4'(k + 1)) begin
        top_id = stack_id[k];
        top_pc = stack_pc[k];
      end
    end
  end

  assign eligible  = gie && cand_valid && (depth_q < 4'(NEST_DEPTH)) &&
                     ((depth_q == 4'd0) || (cand_id < top_id));
  assign ack_take  = (state == ST_REQ) && bus.irq_ack;
  assign rti_pop   = bus.rti && (depth_q != 4'd0);
  assign rti_err   = bus.rti && (depth_q == 4'd0);
  assign depth_pop = depth_q - {3'b000, rti_pop};
  assign push_ok   = ack_take && (depth_pop < 4'(NEST_DEPTH));
  assign push_drop = ack_take && !push_ok;

  // Next pending vector: edge sources latch rising edges (set beats clear), level sources follow the line.
  always_comb begin
    ack_clr = '0;
    if (ack_take) ack_clr[req_id] = 1'b1;
    w1c = (bus.cfg_we && (bus.cfg_addr == 2'd2)) ? bus.cfg_wdata[N_IRQ-1:0] : '0;
    pend_next = (mode & ((pend & ~w1c & ~ack_clr) | (irq_in & ~prev))) | (~mode & irq_in);
  end

  // Config registers, pending latch and the sticky nesting error.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      mode     <= '0;
      pend     <= '0;
      prev     <= '0;
      gie      <= 1'b0;
      nest_err <= 1'b0;
    end else begin
      prev <= irq_in;
      pend <= pend_next;
      if (mask_we) mask <= bus.cfg_wdata[N_IRQ-1:0];
      if (mode_we) mode <= bus.cfg_wdata[N_IRQ-1:0];
      if (ctrl_we) gie <= bus.cfg_wdata[0];
      if (rti_err || push_drop) nest_err <= 1'b1;
      else if (ctrl_we && bus.cfg_wdata[1]) nest_err <= 1'b0;
    end
  end

  // In-service stack: an rti pops first, then an ack pushes, so both together replace the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
        stack_id[k] <= '0;
        stack_pc[k] <= '0;
      end
    end else begin
      depth_q <= depth_pop + {3'b000, push_ok};
      for (int k = 0; k < NEST_DEPTH; k++) begin
        if (push_ok && (depth_pop == 4'(k))) begin
          stack_id[k] <= req_id;
          stack_pc[k] <= bus.ack_pc;
        end
      end
    end
  end

  // Request FSM: once a request is offered its id and vector stay frozen until the core acks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      req_id <= '0;
      vector <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eligible) begin
            state  <= ST_REQ;
            req_id <= cand_id;
            vector <= VEC_BASE + 32'(cand_id) * 32'(VEC_STRIDE);
          end
        end
        ST_REQ: begin
          if (ack_take) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register window read; STATUS holds GIE in bit 0, nest_err in bit 1, depth in [7:4], top id in [12:8].
  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      2'd0: bus.cfg_rdata[N_IRQ-1:0] = mask;
      2'd1: bus.cfg_rdata[N_IRQ-1:0] = mode;
      2'd2: bus.cfg_rdata[N_IRQ-1:0] = pend;
      default: begin
        bus.cfg_rdata[0]    = gie;
        bus.cfg_rdata[1]    = nest_err;
        bus.cfg_rdata[7:4]  = depth_q;
        bus.cfg_rdata[12:8] = 5'(top_id);
      end
    endcase
  end

  assign bus.irq_req    = (state == ST_REQ);
  assign bus.irq_vector = vector;
  assign bus.rti_pc     = top_pc;
  assign bus.depth      = depth_q;
  assign bus.nest_err   = nest_err;
endmodule
